mem_access_ctrl: RTL and testbench

- Data-side memory access controller in the MEM stage, directly downstream of the address-translation unit.
- Consumes the translated physical address and the cached attribute, and routes each load or store to either the D-cache port or the uncached port.
- Both ports use an SRAM-like handshake (req/addr_ok/data_ok). The block generates byte strobes, aligns and extends load data, and stalls the pipeline until the access completes.

---
 rtl/mem_access_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data access controller: routes loads/stores to the D-cache or
// uncached SRAM-like port, builds strobes/lane data and aligns load data.
module mem_access_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_wr,
  input  logic [1:0]    req_size,
  input  logic          req_sign,
  input  logic [AW-1:0] req_paddr,
  input  logic          req_cached,
  input  logic [DW-1:0] req_wdata,
  input  logic          flush,
  output logic          stall,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          dc_req,
  output logic          dc_wr,
  output logic [1:0]    dc_size,
  output logic [3:0]    dc_wstrb,
  output logic [AW-1:0] dc_addr,
  output logic [DW-1:0] dc_wdata,
  input  logic          dc_addr_ok,
  input  logic          dc_data_ok,
  input  logic [DW-1:0] dc_rdata,
  output logic          uc_req,
  output logic          uc_wr,
  output logic [1:0]    uc_size,
  output logic [3:0]    uc_wstrb,
  output logic [AW-1:0] uc_addr,
  output logic [DW-1:0] uc_wdata,
  input  logic          uc_addr_ok,
  input  logic          uc_data_ok,
  input  logic [DW-1:0] uc_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_drop;
  logic          r_wr;
  logic [1:0]    r_size;
  logic          r_sign;
  logic [AW-1:0] r_paddr;
  logic          r_cached;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_wstrb;
  logic [DW-1:0] r_rdata;

  logic          w_sel_addr_ok;
  logic          w_sel_data_ok;
  logic [DW-1:0] w_sel_rdata;

  function automatic logic [3:0] f_strobe(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << off;
      2'd1:    s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [DW-1:0] f_lanes(input logic [1:0] size, input logic [DW-1:0] wd);
    logic [DW-1:0] d;
    case (size)
      2'd0:    d = {4{wd[7:0]}};
      2'd1:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [DW-1:0] f_extract(input logic [1:0] size, input logic sign,
                                              input logic [1:0] off, input logic [DW-1:0] rd);
    logic [DW-1:0] sh;
    logic [DW-1:0] d;
    case (size)
      2'd0: begin
        sh = rd >> {off, 3'b000};
        d  = {{(DW-8){sign & sh[7]}}, sh[7:0]};
      end
      2'd1: begin
        sh = rd >> {off[1], 4'b0000};
        d  = {{(DW-16){sign & sh[15]}}, sh[15:0]};
      end
      default: begin
        sh = rd;
        d  = rd;
      end
    endcase
    return d;
  endfunction

  // Handshake inputs from the port not owning the transaction are ignored
  assign w_sel_addr_ok = r_cached ? dc_addr_ok : uc_addr_ok;
  assign w_sel_data_ok = r_cached ? dc_data_ok : uc_data_ok;
  assign w_sel_rdata   = r_cached ? dc_rdata   : uc_rdata;

  // State register, latched request fields, drop flag and load data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_drop   <= 1'b0;
      r_wr     <= 1'b0;
      r_size   <= 2'd0;
      r_sign   <= 1'b0;
      r_paddr  <= '0;
      r_cached <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= 4'd0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid && !flush) begin
            r_wr     <= req_wr;
            r_size   <= req_size;
            r_sign   <= req_sign;
            r_paddr  <= req_paddr;
            r_cached <= req_cached;
            r_wdata  <= f_lanes(req_size, req_wdata);
            r_wstrb  <= f_strobe(req_size, req_paddr[1:0]);
          end
        end
        // A request accepted in the same cycle as flush must still be drained
        S_REQ: begin
          if (flush && w_sel_addr_ok) begin
            r_drop <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_sel_data_ok) begin
            r_rdata <= r_wr ? '0 : f_extract(r_size, r_sign, r_paddr[1:0], w_sel_rdata);
            r_drop  <= 1'b0;
          end else if (flush) begin
            r_drop <= 1'b1;
          end
        end
        default: begin
          r_drop <= r_drop;
        end
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid && !flush) w_next = S_REQ;
        else                     w_next = S_IDLE;
      end
      S_REQ: begin
        if (w_sel_addr_ok) w_next = S_WAIT;
        else if (flush)    w_next = S_IDLE;
        else               w_next = S_REQ;
      end
      S_WAIT: begin
        if (w_sel_data_ok) w_next = (r_drop || flush) ? S_IDLE : S_DONE;
        else               w_next = S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign stall = !flush & (((r_state == S_IDLE) & req_valid) |
                           (r_state == S_REQ) |
                           ((r_state == S_WAIT) & (!r_drop | req_valid)));

  assign resp_valid = (r_state == S_DONE);
  assign resp_rdata = resp_valid ? r_rdata : '0;

  // Only the owning port sees the request; the other port stays quiet
  assign dc_req   = (r_state == S_REQ) & r_cached;
  assign dc_wr    = r_cached & r_wr;
  assign dc_size  = r_cached ? r_size  : 2'd0;
  assign dc_wstrb = r_cached ? r_wstrb : 4'd0;
  assign dc_addr  = r_cached ? r_paddr : '0;
  assign dc_wdata = r_cached ? r_wdata : '0;

  assign uc_req   = (r_state == S_REQ) & !r_cached;
  assign uc_wr    = !r_cached & r_wr;
  assign uc_size  = r_cached ? 2'd0 : r_size;
  assign uc_wstrb = r_cached ? 4'd0 : r_wstrb;
  assign uc_addr  = r_cached ? '0 : r_paddr;
  assign uc_wdata = r_cached ? '0 : r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// transactions against an arithmetic reference model.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid, req_wr, req_sign, req_cached, flush;
  logic [1:0]  req_size;
  logic [31:0] req_paddr, req_wdata;
  logic        stall, resp_valid;
  logic [31:0] resp_rdata;
  logic        dc_req, dc_wr, uc_req, uc_wr;
  logic [1:0]  dc_size, uc_size;
  logic [3:0]  dc_wstrb, uc_wstrb;
  logic [31:0] dc_addr, dc_wdata, uc_addr, uc_wdata;
  logic        dc_addr_ok, dc_data_ok, uc_addr_ok, uc_data_ok;
  logic [31:0] dc_rdata, uc_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size), .req_sign(req_sign),
    .req_paddr(req_paddr), .req_cached(req_cached), .req_wdata(req_wdata), .flush(flush),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_size(dc_size), .dc_wstrb(dc_wstrb),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_addr_ok(dc_addr_ok), .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata),
    .uc_req(uc_req), .uc_wr(uc_wr), .uc_size(uc_size), .uc_wstrb(uc_wstrb),
    .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .uc_addr_ok(uc_addr_ok), .uc_data_ok(uc_data_ok), .uc_rdata(uc_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_strb(input int size, input logic [31:0] a);
    int off = int'(a % 4);
    if (size == 0) return 4'(2 ** off);
    if (size == 1) return (off >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input int size, input logic [31:0] w);
    if (size == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (size == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_rdata(input bit wr, input int size, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] r);
    longint v;
    int     nbits;
    if (wr) return 32'd0;
    if (size == 0) begin
      v = (longint'(r) >> (8 * (a % 4))) % 256;
      nbits = 8;
    end else if (size == 1) begin
      v = (longint'(r) >> (16 * ((a / 2) % 2))) % 65536;
      nbits = 16;
    end else begin
      v = longint'(r);
      nbits = 32;
    end
    if (sgn && nbits < 32 && v >= (longint'(1) << (nbits - 1)))
      v = v - (longint'(1) << nbits);
    return 32'(v);
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_valid = 0; req_wr = 0; req_size = 0; req_sign = 0; req_paddr = 0;
    req_cached = 0; req_wdata = 0; flush = 0;
    dc_addr_ok = 0; dc_data_ok = 0; dc_rdata = 0;
    uc_addr_ok = 0; uc_data_ok = 0; uc_rdata = 0;
  endtask

  task automatic set_req(input bit wr, input int size, input bit sgn, input logic [31:0] a,
                         input bit cached, input logic [31:0] wd);
    req_valid = 1; req_wr = wr; req_size = 2'(size); req_sign = sgn;
    req_paddr = a; req_cached = cached; req_wdata = wd;
  endtask

  task automatic drive_ports(input bit cached, input bit s_aok, input bit s_dok,
                             input logic [31:0] s_rd, input bit o_aok, input bit o_dok);
    if (cached) begin
      dc_addr_ok = s_aok; dc_data_ok = s_dok; dc_rdata = s_rd;
      uc_addr_ok = o_aok; uc_data_ok = o_dok; uc_rdata = $urandom;
    end else begin
      uc_addr_ok = s_aok; uc_data_ok = s_dok; uc_rdata = s_rd;
      dc_addr_ok = o_aok; dc_data_ok = o_dok; dc_rdata = $urandom;
    end
  endtask

  task automatic chk_port(input string tag, input bit wr, input int size, input logic [31:0] a,
                          input bit cached, input logic [31:0] wd);
    logic [71:0] obs;
    logic [71:0] exp;
    obs = cached ? {dc_req, dc_wr, dc_size, dc_wstrb, dc_addr, dc_wdata}
                 : {uc_req, uc_wr, uc_size, uc_wstrb, uc_addr, uc_wdata};
    exp = {1'b1, wr, 2'(size), m_strb(size, a), a, m_wdata(size, wd)};
    chk({tag, "_port"}, obs, exp);
    chk({tag, "_other_req"}, cached ? uc_req : dc_req, 0);
  endtask

  // One full transaction: ad cycles of withheld addr_ok, dd cycles of withheld data_ok
  task automatic run_txn(input string tag, input bit wr, input int size, input bit sgn,
                         input logic [31:0] a, input bit cached, input logic [31:0] wd,
                         input logic [31:0] rd, input int ad, input int dd);
    step();
    set_req(wr, size, sgn, a, cached, wd);
    smp();
    chk({tag, "_c0_stall"}, stall, 1);
    chk({tag, "_c0_req"}, {dc_req, uc_req}, 0);
    for (int k = 0; k <= ad; k++) begin
      step();
      req_valid = 0;
      drive_ports(cached, k == ad, $urandom_range(0, 1), $urandom, 1, 1);
      smp();
      chk_port({tag, "_req"}, wr, size, a, cached, wd);
      chk({tag, "_req_stall"}, stall, 1);
    end
    for (int k = 0; k <= dd; k++) begin
      step();
      drive_ports(cached, 0, k == dd, (k == dd) ? rd : $urandom, 1, 1);
      smp();
      chk({tag, "_wait_stall"}, stall, 1);
      chk({tag, "_wait_resp"}, {resp_valid, dc_req, uc_req}, 0);
    end
    step();
    clear_inputs();
    smp();
    chk({tag, "_done"}, {resp_valid, stall, resp_rdata}, {1'b1, 1'b0, m_rdata(wr, size, sgn, a, rd)});
    step();
    smp();
    chk({tag, "_pulse"}, resp_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    smp();
    chk("reset_out", {stall, resp_valid, resp_rdata, dc_req, uc_req, dc_addr, uc_addr, dc_wstrb, uc_wstrb}, 0);

    run_txn("c_word_ld", 0, 2, 0, 32'h0000_1004, 1, 32'h0, 32'hDEAD_BEEF, 0, 0);
    run_txn("u_sbyte_ld", 0, 0, 1, 32'h1FAF_F003, 0, 32'h0, 32'h8012_3456, 0, 0);
    run_txn("u_ubyte_ld", 0, 0, 0, 32'h1FAF_F003, 0, 32'h0, 32'h8012_3456, 1, 2);
    run_txn("u_half_st", 1, 1, 0, 32'h0000_0002, 0, 32'h0000_1234, 32'h5555_5555, 0, 1);

    // addr_ok withheld, flush on the third REQ cycle
    step();
    set_req(1, 2, 0, 32'h2000_0010, 0, 32'hCAFE_F00D);
    for (int k = 1; k <= 3; k++) begin
      step();
      req_valid = 0;
      flush = (k == 3);
      smp();
      chk_port("flush_req", 1, 2, 32'h2000_0010, 0, 32'hCAFE_F00D);
      chk("flush_req_stall", stall, (k == 3) ? 0 : 1);
    end
    for (int k = 4; k <= 5; k++) begin
      step();
      flush = 0;
      smp();
      chk("flush_req_after", {uc_req, dc_req, resp_valid, stall}, 0);
    end

    // flush in WAIT with a new request waiting behind it
    step();
    set_req(0, 2, 0, 32'h0000_0100, 1, 32'h0);
    step();
    req_valid = 0;
    dc_addr_ok = 1;
    step();
    dc_addr_ok = 0;
    flush = 1;
    set_req(0, 0, 0, 32'h0000_0201, 0, 32'h0);
    smp();
    chk("wflush_stall_flush", stall, 0);
    for (int k = 0; k < 2; k++) begin
      step();
      flush = 0;
      dc_data_ok = (k == 1);
      dc_rdata = 32'h1111_1111;
      smp();
      chk("wflush_drain", {stall, resp_valid, dc_req, uc_req}, 4'b1000);
    end
    step();
    dc_data_ok = 0;
    smp();
    chk("wflush_idle", {stall, resp_valid, dc_req, uc_req}, 4'b1000);
    step();
    req_valid = 0;
    uc_addr_ok = 1;
    smp();
    chk("wflush_new_req", {uc_req, dc_req, resp_valid, uc_addr}, {3'b100, 32'h0000_0201});
    step();
    uc_addr_ok = 0;
    uc_data_ok = 1;
    uc_rdata = 32'h0000_AB00;
    step();
    uc_data_ok = 0;
    smp();
    chk("wflush_new_resp", {resp_valid, resp_rdata}, {1'b1, 32'h0000_00AB});

    // reset while in WAIT; a late data_ok afterwards is ignored
    step();
    set_req(0, 2, 0, 32'h0000_0300, 1, 32'h0);
    step();
    req_valid = 0;
    dc_addr_ok = 1;
    step();
    dc_addr_ok = 0;
    rst = 1;
    step();
    rst = 0;
    dc_data_ok = 1;
    dc_rdata = 32'h7777_7777;
    smp();
    chk("rst_wait_out", {stall, resp_valid, resp_rdata, dc_req, uc_req, dc_addr, dc_wstrb}, 0);
    step();
    dc_data_ok = 0;
    smp();
    chk("rst_late_dok", {stall, resp_valid, dc_req, uc_req}, 0);

    // randomized transactions
    for (int i = 0; i < 30; i++) begin
      int          sz;
      logic [31:0] a;
      sz = $urandom_range(0, 2);
      a  = $urandom;
      if (sz == 1) a[0] = 1'b0;
      if (sz == 2) a[1:0] = 2'b00;
      run_txn("rand", 1'($urandom), sz, 1'($urandom), a, 1'($urandom), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
